// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: memory op and FSM enums, funct3 codes,
// and the latched-request payload.
package load_store_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Memory op held across the bus transaction
    typedef struct packed {
        logic       is_load;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
        logic [4:0] rd;
    } lsu_req_t;

    // Access width; unrecognised funct3 encodings fall back to a full word
    function automatic acc_size_t access_size(input mem_op_t op, input logic [2:0] funct3);
        acc_size_t sz;
        sz = SZ_W;
        if (op == MEM_LOAD) begin
            case (funct3)
                F3_B, F3_BU: sz = SZ_B;
                F3_H, F3_HU: sz = SZ_H;
                default:     sz = SZ_W;
            endcase
        end else begin
            case (funct3)
                F3_B:    sz = SZ_B;
                F3_H:    sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/load_store_unit_load_aligner.sv
// Combinational load data extraction: selects the byte/half lane and sign- or zero-extends.
module load_aligner
    import load_store_unit_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_c = rdata[7:0];
            2'd1:    byte_c = rdata[15:8];
            2'd2:    byte_c = rdata[23:16];
            default: byte_c = rdata[31:24];
        endcase
        half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data_c = {{24{byte_c[7]}}, byte_c};
            F3_BU:   load_data_c = {24'h000000, byte_c};
            F3_H:    load_data_c = {{16{half_c[15]}}, half_c};
            F3_HU:   load_data_c = {16'h0000, half_c};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: data-memory request/ack handshake, store lane alignment and load extraction.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses are reported, not issued.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [1:0]      ex_mem_op,
    input  logic [2:0]      ex_funct3,
    input  logic [4:0]      ex_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_we,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_misalign
);

    lsu_state_t      state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic            ex_ready_d, dmem_req_d, dmem_we_d, wb_valid_d, wb_we_d, wb_misalign_d;
    logic [XLEN-1:0] dmem_addr_d, dmem_wdata_d, wb_data_d;
    logic [3:0]      dmem_wstrb_d;
    logic [4:0]      wb_rd_d;

    mem_op_t         op_c;
    acc_size_t       size_c;
    logic            is_mem_c, misalign_c;
    logic [1:0]      addr_lo_c;
    logic [3:0]      strb_c;
    logic [XLEN-1:0] wdata_c, load_data_c;

    // Decode the incoming op: access size, effective low address bits, misalignment
    always_comb begin
        op_c     = mem_op_t'(ex_mem_op);
        is_mem_c = (op_c == MEM_LOAD) || (op_c == MEM_STORE);
        size_c   = access_size(op_c, ex_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        addr_lo_c  = ex_alu_out[1:0];
        misalign_c = is_mem_c &&
                     (((size_c == SZ_H) && ex_alu_out[0]) ||
                      ((size_c == SZ_W) && (ex_alu_out[1:0] != 2'b00)));
`else
        misalign_c = 1'b0;
        case (size_c)
            SZ_H:    addr_lo_c = {ex_alu_out[1], 1'b0};
            SZ_W:    addr_lo_c = 2'b00;
            default: addr_lo_c = ex_alu_out[1:0];
        endcase
`endif
    end

    // Store lane replication and byte strobes
    always_comb begin
        case (size_c)
            SZ_B: begin
                strb_c  = 4'b0001 << addr_lo_c;
                wdata_c = {4{ex_store_data[7:0]}};
            end
            SZ_H: begin
                strb_c  = 4'b0011 << {addr_lo_c[1], 1'b0};
                wdata_c = {2{ex_store_data[15:0]}};
            end
            default: begin
                strb_c  = 4'b1111;
                wdata_c = ex_store_data;
            end
        endcase
    end

    load_aligner u_load_aligner (
        .rdata       (dmem_rdata),
        .addr_lo     (req_q.addr_lo),
        .funct3      (req_q.funct3),
        .load_data_c (load_data_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        dmem_req_d    = dmem_req;
        dmem_we_d     = dmem_we;
        dmem_addr_d   = dmem_addr;
        dmem_wdata_d  = dmem_wdata;
        dmem_wstrb_d  = dmem_wstrb;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd;
        wb_we_d       = wb_we;
        wb_data_d     = wb_data;
        wb_misalign_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid && ex_ready) begin
                    if (!is_mem_c || misalign_c) begin
                        wb_valid_d    = 1'b1;
                        wb_rd_d       = ex_rd;
                        wb_we_d       = !misalign_c && (ex_rd != 5'd0);
                        wb_data_d     = ex_alu_out;
                        wb_misalign_d = misalign_c;
                    end else begin
                        state_d       = BUS;
                        req_d.is_load = (op_c == MEM_LOAD);
                        req_d.funct3  = ex_funct3;
                        req_d.addr_lo = addr_lo_c;
                        req_d.rd      = ex_rd;
                        dmem_req_d    = 1'b1;
                        dmem_we_d     = (op_c == MEM_STORE);
                        dmem_addr_d   = {ex_alu_out[XLEN-1:2], 2'b00};
                        dmem_wdata_d  = wdata_c;
                        dmem_wstrb_d  = (op_c == MEM_STORE) ? strb_c : 4'b0000;
                    end
                end
            end
            BUS: begin
                if (dmem_ack) begin
                    state_d    = IDLE;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = req_q.rd;
                    wb_we_d    = req_q.is_load && (req_q.rd != 5'd0);
                    wb_data_d  = req_q.is_load ? load_data_c : '0;
                end
            end
            default: state_d = IDLE;
        endcase

        ex_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            ex_ready    <= 1'b1;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_wstrb  <= 4'b0000;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_we       <= 1'b0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ex_ready    <= ex_ready_d;
            dmem_req    <= dmem_req_d;
            dmem_we     <= dmem_we_d;
            dmem_addr   <= dmem_addr_d;
            dmem_wdata  <= dmem_wdata_d;
            dmem_wstrb  <= dmem_wstrb_d;
            wb_valid    <= wb_valid_d;
            wb_rd       <= wb_rd_d;
            wb_we       <= wb_we_d;
            wb_data     <= wb_data_d;
            wb_misalign <= wb_misalign_d;
        end
    end

endmodule
